// File: rtl/rle_decode.sv
`timescale 1ns/1ps
// rle_decode
//   Run-length decoder. Accepts (run, level) symbols and end-of-block markers
//   and expands them into 8x8 coefficient blocks. Each completed block row
//   (8 coefficients, column 0 in the most significant byte) is presented on a
//   single-entry output register with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   sym_valid  symbol present on sym_run/sym_level/sym_eob
//   sym_ready  decoder accepts the symbol on this edge
//   sym_run    number of zeros preceding the level
//   sym_level  coefficient value written after the zeros
//   sym_eob    end-of-block marker (run/level ignored)
//   row_valid  row_data holds a complete row
//   row_ready  downstream accepts the row
//   row_data   column k at bits [CW*(8-k)-1 -: CW]
//   row_idx    row number 0..7 within the block
//   blk_done   high together with row_valid for row 7
//   err        sticky overflow flag (run/level ran past coefficient 63)
module rle_decode #(
  parameter int CW = 8,
  parameter int RW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sym_valid,
  output logic            sym_ready,
  input  logic [RW-1:0]   sym_run,
  input  logic [CW-1:0]   sym_level,
  input  logic            sym_eob,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [8*CW-1:0] row_data,
  output logic [2:0]      row_idx,
  output logic            blk_done,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [5:0]      pos_q,       pos_d;
  logic [RW-1:0]   run_cnt_q,   run_cnt_d;
  logic [CW-1:0]   level_q,     level_d;
  logic [8*CW-1:0] row_buf_q,   row_buf_d;
  logic            row_valid_q, row_valid_d;
  logic [8*CW-1:0] row_data_q,  row_data_d;
  logic [2:0]      row_idx_q,   row_idx_d;
  logic            blk_done_q,  blk_done_d;
  logic            err_q,       err_d;

  // Combinational helpers
  logic            col7;
  logic            stall;
  logic            wr_en;
  logic [CW-1:0]   wr_data;
  logic            rdy;
  logic            take;
  logic [5:0]      pos_inc;
  logic [8*CW-1:0] row_new;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    run_cnt_d   = run_cnt_q;
    level_d     = level_q;
    row_buf_d   = row_buf_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    blk_done_d  = blk_done_q;
    err_d       = err_q;

    wr_en   = 1'b0;
    wr_data = '0;
    rdy     = 1'b0;
    pos_inc = pos_q + 6'd1;

    // A column-7 write needs the output register; if it still holds an
    // unaccepted row, the whole decoder freezes for this cycle.
    col7  = (pos_q[2:0] == 3'd7);
    stall = col7 & row_valid_q & ~row_ready;

    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
      end
      EXPAND: begin
        if (!stall) begin
          wr_en = 1'b1;
          if (run_cnt_q == '0) begin
            wr_data = level_q;
            // Level cycle: the next symbol may be taken on the same edge.
            rdy     = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          wr_en = 1'b1;
        end
      end
      default: ;
    endcase

    // Held low while reset is asserted.
    take = sym_valid & rdy & reset;

    // ---------------- symbol / expansion control ----------------
    if (wr_en) begin
      pos_d = pos_inc;
    end

    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (!sym_eob) begin
            run_cnt_d = sym_run;
            level_d   = sym_level;
            state_d   = EXPAND;
          end else if (pos_q != 6'd0) begin
            state_d = FLUSH;
          end
          // EOB at pos 0: block already closed, marker is dropped.
        end
      end
      EXPAND: begin
        if (wr_en) begin
          if (run_cnt_q != '0) begin
            run_cnt_d = run_cnt_q - RW'(1);
            if (pos_q == 6'd63) begin
              // Block closes with zeros and a level still owed: drop them.
              err_d     = 1'b1;
              run_cnt_d = '0;
              state_d   = IDLE;
            end
          end else if (take) begin
            if (!sym_eob) begin
              run_cnt_d = sym_run;
              level_d   = sym_level;
              state_d   = EXPAND;
            end else begin
              state_d = (pos_inc != 6'd0) ? FLUSH : IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (wr_en && pos_q == 6'd63) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // ---------------- row assembly / output register ----------------
    row_new = row_buf_q;
    for (int k = 0; k < 8; k++) begin
      if (pos_q[2:0] == 3'(k)) begin
        row_new[CW*(8-k)-1 -: CW] = wr_data;
      end
    end

    if (wr_en && col7) begin
      row_data_d  = row_new;
      row_valid_d = 1'b1;
      row_idx_d   = pos_q[5:3];
      blk_done_d  = (pos_q[5:3] == 3'd7);
      row_buf_d   = '0;
    end else begin
      if (row_ready) begin
        row_valid_d = 1'b0;
        blk_done_d  = 1'b0;
      end
      if (wr_en) begin
        row_buf_d = row_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      run_cnt_q   <= '0;
      level_q     <= '0;
      row_buf_q   <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      blk_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      run_cnt_q   <= run_cnt_d;
      level_q     <= level_d;
      row_buf_q   <= row_buf_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      blk_done_q  <= blk_done_d;
      err_q       <= err_d;
    end
  end

  assign sym_ready = rdy & reset;
  assign row_valid = row_valid_q;
  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign blk_done  = blk_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rle_decode.sv
`timescale 1ns/1ps
// Scoreboard bench for rle_decode: stimulus pushes expected rows, a negedge
// monitor pops and compares every accepted row.
module tb_rle_decode;
  localparam int CW = 8;
  localparam int RW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            sym_valid = 1'b0;
  logic            sym_ready;
  logic [RW-1:0]   sym_run = '0;
  logic [CW-1:0]   sym_level = '0;
  logic            sym_eob = 1'b0;
  logic            row_valid;
  logic            row_ready = 1'b1;
  logic [8*CW-1:0] row_data;
  logic [2:0]      row_idx;
  logic            blk_done;
  logic            err;

  always #5 clk = ~clk;

  rle_decode #(.CW(CW), .RW(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_run   (sym_run),
    .sym_level (sym_level),
    .sym_eob   (sym_eob),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .blk_done  (blk_done),
    .err       (err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  idx;
    logic        blk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   rows_seen = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: one transfer per negedge where valid & ready are both high.
  always @(negedge clk) begin
    if (reset && row_valid && row_ready) begin
      rows_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row: got idx=%0d data=%h want no row", row_idx, row_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("row idx=%0d data=%h blk_done=%0d", row_idx, row_data, blk_done);
        chk("row_data", row_data, mon_e.data);
        chk("row_idx", 64'(row_idx), 64'(mon_e.idx));
        chk("blk_done", 64'(blk_done), 64'(mon_e.blk));
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic [2:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.blk  = (i == 3'd7);
    exp_q.push_back(e);
  endtask

  task automatic push_zero_rows(input int from);
    for (int i = from; i < 8; i++) push(64'd0, 3'(i));
  endtask

  // Row r of the ascending stream (levels 1..64 at run 0).
  function automatic logic [63:0] seq_row(input int r);
    logic [63:0] d;
    d = '0;
    for (int c = 0; c < 8; c++) d[8*(8-c)-1 -: 8] = 8'(8*r + c + 1);
    return d;
  endfunction

  task automatic send(input logic [RW-1:0] r, input logic [CW-1:0] l, input logic e);
    int n;
    n = 0;
    sym_valid = 1'b1;
    sym_run   = r;
    sym_level = l;
    sym_eob   = e;
    @(negedge clk);
    while (!sym_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!sym_ready) begin
      total++;
      bad++;
      $display("FAIL sym_accept_timeout: got sym_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    sym_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int r0;
    int t;
    int n;
    int first_acc;

    // ---------------- reset state ----------------
    #12;
    chk("rst_sym_ready", 64'(sym_ready), 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_row_data", row_data, 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_blk_done", 64'(blk_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- test 1: two levels then EOB ----------------
    r0 = rows_seen;
    push(64'h42_01_00_00_00_00_00_00, 3'd0);
    push_zero_rows(1);
    send(6'd0, 8'h42, 1'b0);
    send(6'd0, 8'h01, 1'b0);
    send(6'd0, 8'h00, 1'b1);
    drain("t1_drain");
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_rows", 64'(rows_seen - r0), 64'd8);

    // ---------------- test 2: run of 13 ----------------
    r0 = rows_seen;
    push(64'h42_00_00_00_00_00_00_00, 3'd0);
    push(64'h00_00_00_00_00_00_0C_00, 3'd1);
    push_zero_rows(2);
    send(6'd0, 8'h42, 1'b0);
    send(6'd13, 8'h0C, 1'b0);
    t = acc_cyc;
    send(6'd0, 8'h00, 1'b1);
    n = 0;
    while (!(row_valid && row_idx == 3'd1) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    // 0C at t+14, pos 15 flushed at t+15 loads row 1.
    chk("t2_row1_latency", 64'(cyc - t), 64'd15);
    drain("t2_drain");
    chk("t2_rows", 64'(rows_seen - r0), 64'd8);

    // ---------------- test 3: full 64-symbol stream ----------------
    r0 = rows_seen;
    for (int r = 0; r < 8; r++) push(seq_row(r), 3'(r));
    first_acc = 0;
    for (int k = 0; k < 64; k++) begin
      send(6'd0, 8'(k + 1), 1'b0);
      if (k == 0) first_acc = acc_cyc;
    end
    send(6'd0, 8'h00, 1'b1);
    chk("t3_rate", 64'(acc_cyc - first_acc), 64'd64);
    drain("t3_drain");
    repeat (20) @(posedge clk);
    #1;
    chk("t3_rows", 64'(rows_seen - r0), 64'd8);

    // ---------------- test 4: output backpressure ----------------
    r0 = rows_seen;
    for (int r = 0; r < 8; r++) push(seq_row(r), 3'(r));
    fork
      begin
        for (int k = 0; k < 64; k++) send(6'd0, 8'(k + 1), 1'b0);
        send(6'd0, 8'h00, 1'b1);
      end
      begin
        int m;
        m = 0;
        while (!(row_valid && row_idx == 3'd0) && m < 100) begin
          @(posedge clk);
          #1;
          m++;
        end
        row_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
          @(posedge clk);
          #1;
          if (k == 1 || k == 10 || k == 20) begin
            chk("t4_hold_data", row_data, seq_row(0));
            chk("t4_hold_valid", 64'(row_valid), 64'd1);
          end
          if (k == 6) chk("t4_ready_before_col7", 64'(sym_ready), 64'd1);
          if (k == 7) chk("t4_stall_at_col7", 64'(sym_ready), 64'd0);
          if (k == 20) chk("t4_stall_held", 64'(sym_ready), 64'd0);
        end
        row_ready = 1'b1;
      end
    join
    drain("t4_drain");
    chk("t4_rows", 64'(rows_seen - r0), 64'd8);

    // ---------------- test 5: overflow ----------------
    r0 = rows_seen;
    push(64'h11_00_00_00_00_00_22_00, 3'd0);
    push_zero_rows(1);
    send(6'd0, 8'h11, 1'b0);
    send(6'd5, 8'h22, 1'b0);
    send(6'd63, 8'h33, 1'b0);
    drain("t5_drain");
    chk("t5_err_set", 64'(err), 64'd1);
    push(64'h55_00_00_00_00_00_00_00, 3'd0);
    push_zero_rows(1);
    send(6'd0, 8'h55, 1'b0);
    send(6'd0, 8'h00, 1'b1);
    drain("t5_drain2");
    chk("t5_err_sticky", 64'(err), 64'd1);
    chk("t5_rows", 64'(rows_seen - r0), 64'd16);

    // ---------------- test 6: reset mid-block ----------------
    push(seq_row(0), 3'd0);
    push(seq_row(1), 3'd1);
    for (int k = 0; k < 20; k++) begin
      send(6'd0, 8'(k + 1), 1'b0);
      // Row 1 has just loaded: hold it so a row is pending at reset.
      if (k == 16) row_ready = 1'b0;
    end
    @(posedge clk);
    #3;
    chk("t6_pending_before_reset", 64'(row_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_row_valid", 64'(row_valid), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_sym_ready", 64'(sym_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    row_ready = 1'b1;
    @(posedge clk);
    #1;
    r0 = rows_seen;
    push(64'h42_00_00_00_00_00_00_00, 3'd0);
    push_zero_rows(1);
    send(6'd0, 8'h42, 1'b0);
    send(6'd0, 8'h00, 1'b1);
    drain("t6_drain");
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_rows", 64'(rows_seen - r0), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
